// File: rtl/image_composer.sv
// -----------------------------------------------------------------------------
// image_composer
//
// Purpose:
//   Composes N stacked RGB layers into one output pixel per cycle. A layer is
//   opaque when its enable bit is set and its pixel differs from the
//   transparent colour key KEY (full 24-bit compare). The highest-index opaque
//   layer wins (layer N-1 on top, layer 0 at the bottom). When no layer is
//   opaque the background colour BG is produced. Pixels are passed through
//   untouched; there is no blending or channel arithmetic.
//
// Parameters:
//   N    number of input layers, legal range 1..16
//   KEY  transparent colour key
//   BG   background colour used when no layer is opaque
//
// Optional feature (compile-time macro):
//   IMAGE_COMPOSER_LAYER_IDX_EN
//     Adds layer_o (winning layer index, $clog2(N) bits, minimum 1) and hit_o
//     (1 when some layer was opaque). Both are registered alongside RGB_o.
//     With no opaque layer, layer_o = 0 and hit_o = 0.
//
// Ports:
//   clk_i    in   1         sole clock, rising edge
//   rst_i    in   1         synchronous active-high reset
//   valid_i  in   1         en_i / RGB_i carry a pixel this cycle
//   en_i     in   N         per-layer enable (0 = treat layer as transparent)
//   RGB_i    in   [N-1:0][23:0]  per-layer pixel {R,G,B}
//   layer_o  out  LIDX_W    winning layer index  (macro only)
//   hit_o    out  1         some layer was opaque (macro only)
//   valid_o  out  1         RGB_o holds a composed pixel
//   RGB_o    out  24        composed pixel
//
// Handshake:
//   Valid-only stream, no ready/backpressure. A pixel is accepted on every
//   rising edge where valid_i=1 and rst_i=0; the composed result appears on
//   RGB_o with valid_o=1 exactly one cycle later. When valid_i=0, valid_o
//   drops to 0 the next cycle and RGB_o (and layer_o/hit_o) keep their
//   previous values. rst_i takes priority over valid_i: a pixel presented in
//   a reset cycle is dropped.
// -----------------------------------------------------------------------------
module image_composer #(
  parameter int          N   = 3,
  parameter logic [23:0] KEY = 24'h000000,
  parameter logic [23:0] BG  = 24'h000000,
  // Width of the layer index; kept at least 1 so N=1 still has a legal port.
  parameter int          LIDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [N-1:0]            en_i,
  input  logic [N-1:0][23:0]      RGB_i,
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
  output logic [LIDX_W-1:0]       layer_o,
  output logic                    hit_o,
`endif
  output logic                    valid_o,
  output logic [23:0]             RGB_o
);

  // ---------------------------------------------------------------------------
  // Layer selection (combinational, input side of the output register only)
  // ---------------------------------------------------------------------------
  logic [N-1:0]        opaque;
  logic [23:0]         sel_rgb;
  logic [LIDX_W-1:0]   sel_idx;
  logic                sel_hit;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      opaque[k] = en_i[k] && (RGB_i[k] != KEY);
    end
  end

  // Scanning upward and letting each later opaque layer overwrite the result
  // gives "highest index wins" without a separate priority encoder.
  always_comb begin
    sel_rgb = BG;
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (opaque[k]) begin
        sel_rgb = RGB_i[k];
        sel_idx = LIDX_W'(k);
        sel_hit = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        valid_d, valid_q;
  logic [23:0] rgb_d,   rgb_q;

  // Without a valid pixel the colour register holds, so RGB_o stays stable
  // through bubbles in the stream.
  always_comb begin
    valid_d = valid_i;
    rgb_d   = valid_i ? sel_rgb : rgb_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rgb_q   <= BG;
    end else begin
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
    end
  end

  assign valid_o = valid_q;
  assign RGB_o   = rgb_q;

`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
  // Index and hit flag follow exactly the same load/hold/reset rules as the
  // colour so the three outputs always describe the same pixel.
  logic [LIDX_W-1:0] layer_d, layer_q;
  logic              hit_d,   hit_q;

  always_comb begin
    layer_d = valid_i ? sel_idx : layer_q;
    hit_d   = valid_i ? sel_hit : hit_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      layer_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      layer_q <= layer_d;
      hit_q   <= hit_d;
    end
  end

  assign layer_o = layer_q;
  assign hit_o   = hit_q;
`else
  // Index/hit are only exported with the optional feature; keep the
  // selection results referenced so the default build stays lint-clean.
  logic unused_sel;
  assign unused_sel = ^{sel_idx, sel_hit};
`endif

endmodule

// File: tb/tb_image_composer.sv
// -----------------------------------------------------------------------------
// tb_image_composer
//
// Drives two instances of image_composer from one stimulus stream:
//   u_dut  : defaults (N=3, KEY=0, BG=0)
//   u_dut2 : N=2, non-zero KEY and BG, so key compare and background path are
//            exercised with values that differ from zero.
// Expected results come from a reference model evaluated when stimulus is
// applied and queued; they are popped when the DUT raises valid_o.
// If IMAGE_COMPOSER_LAYER_IDX_EN is defined the index/hit outputs are checked
// as well.
// -----------------------------------------------------------------------------
module tb_image_composer;

  localparam int          N    = 3;
  localparam int          N2   = 2;
  localparam logic [23:0] KEY2 = 24'hFF00FF;
  localparam logic [23:0] BG2  = 24'h0A0B0C;
  localparam int          W    = 30; // {hit, idx[4:0], rgb[23:0]}

  // clock / reset ------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst   = 1'b1;
  logic                 valid = 1'b0;
  logic [N-1:0]         en    = '0;
  logic [N-1:0][23:0]   rgb   = '0;
  logic [N2-1:0]        en2   = '0;
  logic [N2-1:0][23:0]  rgb2  = '0;

  logic                 valid_o, valid2_o;
  logic [23:0]          rgb_o, rgb2_o;
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
  logic [1:0]           layer_o;
  logic                 hit_o;
  logic [0:0]           layer2_o;
  logic                 hit2_o;
`endif

  image_composer #(.N(N)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid),
    .en_i    (en),
    .RGB_i   (rgb),
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
    .layer_o (layer_o),
    .hit_o   (hit_o),
`endif
    .valid_o (valid_o),
    .RGB_o   (rgb_o)
  );

  image_composer #(.N(N2), .KEY(KEY2), .BG(BG2)) u_dut2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid),
    .en_i    (en2),
    .RGB_i   (rgb2),
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
    .layer_o (layer2_o),
    .hit_o   (hit2_o),
`endif
    .valid_o (valid2_o),
    .RGB_o   (rgb2_o)
  );

  // scoreboard ---------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] hold1 = {1'b0, 5'd0, 24'h000000};
  logic [W-1:0] hold2 = {1'b0, 5'd0, BG2};
  int errors = 0;
  int checks = 0;

  // Reference: search from the top layer down, first opaque layer wins.
  function automatic logic [W-1:0] model(input int n, input logic [15:0] e,
                                         input logic [15:0][23:0] p,
                                         input logic [23:0] key,
                                         input logic [23:0] bg);
    for (int k = n - 1; k >= 0; k--) begin
      if (e[k] && p[k] != key) return {1'b1, 5'(k), p[k]};
    end
    return {1'b0, 5'd0, bg};
  endfunction

  // One clock cycle: apply inputs, queue expectations, check both DUTs.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [N-1:0] e, input logic [N-1:0][23:0] p,
                      input logic [N2-1:0] e2, input logic [N2-1:0][23:0] p2);
    logic [15:0]        ea, eb;
    logic [15:0][23:0]  pa, pb;
    logic [W-1:0]       x;
    ea = '0; eb = '0; pa = '0; pb = '0;
    for (int i = 0; i < N; i++)  begin ea[i] = e[i];  pa[i] = p[i];  end
    for (int i = 0; i < N2; i++) begin eb[i] = e2[i]; pb[i] = p2[i]; end
    rst = r; valid = v; en = e; rgb = p; en2 = e2; rgb2 = p2;
    if (!r && v) begin
      exp_q.push_back(model(N, ea, pa, 24'h000000, 24'h000000));
      exp2_q.push_back(model(N2, eb, pb, KEY2, BG2));
    end
    @(posedge clk);
    #1;
    if (r) begin
      hold1 = {1'b0, 5'd0, 24'h000000};
      hold2 = {1'b0, 5'd0, BG2};
    end

    // ---- u_dut ----
    checks++;
    if (valid_o !== (!r && v)) begin
      errors++;
      $display("FAIL %s valid_o: got %b expected %b", tag, valid_o, (!r && v));
    end
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: valid_o with empty expected queue, RGB_o=%h", tag, rgb_o);
      end else begin
        hold1 = exp_q.pop_front();
      end
    end
    x = hold1;
    checks++;
    if (rgb_o !== x[23:0]) begin
      errors++;
      $display("FAIL %s RGB_o: got %h expected %h", tag, rgb_o, x[23:0]);
    end
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
    checks++;
    if (layer_o !== x[25:24] || hit_o !== x[29]) begin
      errors++;
      $display("FAIL %s layer_o/hit_o: got %0d/%b expected %0d/%b", tag, layer_o, hit_o,
               x[25:24], x[29]);
    end
`endif

    // ---- u_dut2 ----
    checks++;
    if (valid2_o !== (!r && v)) begin
      errors++;
      $display("FAIL %s valid_o(dut2): got %b expected %b", tag, valid2_o, (!r && v));
    end
    if (valid2_o === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: dut2 valid_o with empty expected queue, RGB_o=%h", tag, rgb2_o);
      end else begin
        hold2 = exp2_q.pop_front();
      end
    end
    x = hold2;
    checks++;
    if (rgb2_o !== x[23:0]) begin
      errors++;
      $display("FAIL %s RGB_o(dut2): got %h expected %h", tag, rgb2_o, x[23:0]);
    end
`ifdef IMAGE_COMPOSER_LAYER_IDX_EN
    checks++;
    if (layer2_o !== x[24] || hit2_o !== x[29]) begin
      errors++;
      $display("FAIL %s layer_o/hit_o(dut2): got %0d/%b expected %0d/%b", tag, layer2_o,
               hit2_o, x[24], x[29]);
    end
`endif
  endtask

  // tests ---------------------------------------------------------------------
  task automatic test_reset();
    // Pixel presented during reset must be dropped; outputs at BG / invalid.
    step("reset0", 1'b1, 1'b1, 3'b111, {24'h111111, 24'h222222, 24'h333333},
         2'b11, {24'h123123, 24'h456456});
    step("reset1", 1'b1, 1'b1, 3'b111, {24'h111111, 24'h222222, 24'h333333},
         2'b11, {24'h123123, 24'h456456});
    // First valid after reset appears one cycle later.
    step("first_idle", 1'b0, 1'b0, 3'b111, {24'h111111, 24'h222222, 24'h333333},
         2'b11, {24'h123123, 24'h456456});
  endtask

  task automatic test_priority();
    step("bottom_only", 1'b0, 1'b1, 3'b111, {24'h000000, 24'h000000, 24'h222222},
         2'b11, {KEY2, 24'h010203});
    step("mid_wins", 1'b0, 1'b1, 3'b111, {24'h000000, 24'h333333, 24'h222222},
         2'b11, {24'h0000FF, 24'h010203});
    step("top_wins", 1'b0, 1'b1, 3'b111, {24'h444444, 24'h333333, 24'h222222},
         2'b11, {KEY2, KEY2});
    step("top_only", 1'b0, 1'b1, 3'b111, {24'h555555, 24'h000000, 24'h000000},
         2'b11, {24'hFF00FE, KEY2});
    step("top_over_mid", 1'b0, 1'b1, 3'b111, {24'h555555, 24'h444444, 24'h000000},
         2'b11, {24'h000000, 24'hFFFFFF});
    step("all_key_bg", 1'b0, 1'b1, 3'b111, {24'h000000, 24'h000000, 24'h000000},
         2'b11, {KEY2, KEY2});
  endtask

  task automatic test_enable();
    step("en_011", 1'b0, 1'b1, 3'b011, {24'h444444, 24'h333333, 24'h222222},
         2'b01, {24'h777777, 24'h888888});
    step("en_000", 1'b0, 1'b1, 3'b000, {24'h444444, 24'h333333, 24'h222222},
         2'b00, {24'h777777, 24'h888888});
    step("en_101", 1'b0, 1'b1, 3'b101, {24'h000000, 24'h333333, 24'h222222},
         2'b10, {KEY2, 24'h888888});
    step("en_110", 1'b0, 1'b1, 3'b110, {24'h000000, 24'h000000, 24'hABCDEF},
         2'b10, {24'hFEDCBA, 24'h888888});
  endtask

  task automatic test_valid_toggle();
    step("vt_1", 1'b0, 1'b1, 3'b111, {24'h000000, 24'h000000, 24'h121212},
         2'b11, {24'h343434, 24'h565656});
    // Different pixel during the bubble: output must not follow it.
    step("vt_0", 1'b0, 1'b0, 3'b111, {24'h999999, 24'h888888, 24'h777777},
         2'b11, {24'h0F0F0F, 24'hF0F0F0});
    step("vt_1b", 1'b0, 1'b1, 3'b111, {24'h000000, 24'h6A6A6A, 24'h000000},
         2'b01, {24'h0F0F0F, 24'h5A5A5A});
    step("vt_0b", 1'b0, 1'b0, 3'b000, {24'h000000, 24'h000000, 24'h000000},
         2'b00, {KEY2, KEY2});
  endtask

  task automatic test_reset_midstream();
    step("ms_pre", 1'b0, 1'b1, 3'b111, {24'hC0FFEE, 24'h000000, 24'h000000},
         2'b11, {24'hBEEF00, 24'h000000});
    step("ms_rst", 1'b1, 1'b1, 3'b111, {24'hDEAD00, 24'h000000, 24'h000000},
         2'b11, {24'h00DEAD, 24'h000000});
    step("ms_post", 1'b0, 1'b1, 3'b001, {24'h000000, 24'h000000, 24'h3C3C3C},
         2'b01, {24'h000000, 24'h3C3C3C});
  endtask

  function automatic logic [23:0] pick(input logic [23:0] key);
    case ($urandom_range(0, 3))
      0:       return key;
      1:       return key ^ 24'h000001;
      default: return 24'($urandom());
    endcase
  endfunction

  task automatic test_back_to_back();
    logic [N-1:0][23:0]  p;
    logic [N2-1:0][23:0] p2;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++)  p[i]  = pick(24'h000000);
      for (int i = 0; i < N2; i++) p2[i] = pick(KEY2);
      step("b2b", 1'b0, ($urandom_range(0, 4) != 0), N'($urandom_range(0, 7)), p,
           N2'($urandom_range(0, 3)), p2);
    end
  endtask

  // main ----------------------------------------------------------------------
  initial begin
    test_reset();
    test_priority();
    test_enable();
    test_valid_toggle();
    test_reset_midstream();
    test_back_to_back();
    step("drain", 1'b0, 1'b0, 3'b000, '0, 2'b00, '0);
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected pixels never produced, required 0/0",
               exp_q.size(), exp2_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/image_composer.md
IMAGE_COMPOSER -- requirements
Module: ImageComposer

Interface
REQ-001 Parameter N, default 3: number of input layers, legal range 1..16.
REQ-002 Parameter KEY, default 24'h000000: transparent colour key.
REQ-003 Parameter BG, default 24'h000000: background colour, output when no layer is opaque.
REQ-004 One clock; reset is synchronous and active-high; ports clk_i and rst_i.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 valid_i  input  1  RGB_i/en_i carry a valid pixel this cycle.
REQ-008 en_i  input  N  per-layer enable; bit k=0 treats layer k as transparent.
REQ-009 RGB_i  input  N x 24 (packed [N-1:0][23:0])  per-layer pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-010 valid_o  output  1  RGB_o holds a composed pixel.
REQ-011 RGB_o  output  24  composed pixel.

Function
REQ-012 Layer k is opaque iff en_i[k]=1 and RGB_i[k] != KEY (full 24-bit compare).
REQ-013 Priority: highest-index opaque layer wins (layer N-1 on top, layer 0 bottom).
REQ-014 Composed value = RGB_i[winner]; BG if no layer is opaque.
REQ-015 Latency exactly 1 clk_i cycle: RGB_o and valid_o register the result computed from inputs sampled at the same edge.
REQ-016 valid_o(t+1) = valid_i(t); when valid_i=0, RGB_o holds its previous value.
REQ-017 Pixels pass through unmodified; no arithmetic, blending or saturation on colour channels.
REQ-018 Back-to-back valid pixels accepted every cycle; no backpressure, no stall.
REQ-019 Selection logic is purely combinational between input and output register; no combinational input-to-output path.

Reset
REQ-020 While rst_i=1 at a clk_i edge: RGB_o <= BG, valid_o <= 0, layer_o <= 0 (when present).
REQ-021 rst_i dominates valid_i; a pixel presented in a reset cycle is dropped.
REQ-022 First valid output appears one cycle after the first valid_i sampled with rst_i=0.

Configuration
REQ-023 Macro IMAGE_COMPOSER_LAYER_IDX_EN: when defined, adds output layer_o, width $clog2(N) (min 1), registered with RGB_o, giving the winning layer index.
REQ-024 When no layer is opaque with the macro defined, layer_o = 0 and hit_o = 0; hit_o (1 bit, output, added by the same macro) = 1 iff some layer was opaque.
REQ-025 Without the macro, layer_o and hit_o do not exist; RGB_o/valid_o behaviour is identical.

Verification
REQ-026 N=3, en_i=3'b111, valid_i=1; RGB_i={0,0,24'h222222} -> next cycle RGB_o=24'h222222.
REQ-027 RGB_i={0,24'h333333,24'h222222} -> RGB_o=24'h333333; {24'h444444,24'h333333,24'h222222} -> 24'h444444.
REQ-028 RGB_i={24'h555555,0,0} -> 24'h555555; {24'h555555,24'h444444,0} -> 24'h555555; all zero -> BG (24'h000000), hit_o=0.
REQ-029 RGB_i={24'h444444,24'h333333,24'h222222}, en_i=3'b011 -> RGB_o=24'h333333, layer_o=1 (macro defined).
REQ-030 rst_i=1 mid-stream with valid_i=1 -> next cycle valid_o=0, RGB_o=BG; valid_i toggling 1,0,1 -> valid_o 1,0,1 delayed one cycle with RGB_o held during the 0.
